// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//   Receive-side byte buffer placed directly behind the UART core. Each rising
//   edge of rx_done captures one byte into a DEPTH-entry circular FIFO. The host
//   reads through a first-word-fall-through valid/ready port. A sticky overflow
//   flag records dropped bytes. An almost_full flag supports flow control.
//
// Ports
//   clk          in   system clock (shared with the UART core)
//   reset        in   asynchronous, active-low reset
//   rx_data      in   [7:0] received byte, stable while rx_done is high
//   rx_done      in   byte-complete strobe, may stay high for several clocks
//   rd_ready     in   host accepts rd_data this cycle
//   ovf_clr      in   synchronous clear of the sticky overflow flag
//   rd_valid     out  FIFO non-empty, rd_data is valid
//   rd_data      out  [7:0] head-of-FIFO byte, 8'h00 when empty
//   count        out  [ADDR_W:0] number of stored entries, 0..DEPTH
//   full         out  count == DEPTH
//   almost_full  out  count >= AFULL
//   overflow     out  sticky: a byte was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int AFULL  = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  input  logic              rd_ready,
  input  logic              ovf_clr,
  output logic              rd_valid,
  output logic [7:0]        rd_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              almost_full,
  output logic              overflow
);

  localparam logic [ADDR_W:0] AFULL_C = (ADDR_W + 1)'(AFULL);

  // Pointers carry one extra wrap bit. This lets full and empty be told apart.
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic            rx_done_q;
  logic            overflow_q, overflow_d;
  logic [7:0]      mem_q [DEPTH];

  logic            empty_s;
  logic            full_s;
  logic            push_s;
  logic            pop_s;
  logic            wr_en_s;
  logic            drop_s;
  logic [ADDR_W:0] count_s;

  // Status decode from the registered pointers.
  always_comb begin
    empty_s = (wr_ptr_q == rd_ptr_q);
    full_s  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
              (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
    count_s = wr_ptr_q - rd_ptr_q;
  end

  // Handshake decode. When the FIFO is full, a pop in the same cycle frees the slot the push needs.
  always_comb begin
    push_s  = rx_done & ~rx_done_q;
    pop_s   = ~empty_s & rd_ready;
    wr_en_s = push_s & (~full_s | pop_s);
    drop_s  = push_s & full_s & ~pop_s;
  end

  // Next-state for pointers and the sticky overflow flag. A drop has priority over a clear.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + {{ADDR_W{1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + {{ADDR_W{1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Control state registers. Reset discards all stored bytes at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rx_done_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rx_done_q  <= rx_done;
      overflow_q <= overflow_d;
    end
  end

  // Storage array. It has no reset, because a slot is read only after it has been written.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= rx_data;
    end
  end

  // Output drive. The read port is first-word-fall-through, and the head byte is masked to zero when empty.
  always_comb begin
    rd_valid    = ~empty_s;
    count       = count_s;
    full        = full_s;
    almost_full = (count_s >= AFULL_C);
    overflow    = overflow_q;
    if (!empty_s) begin
      rd_data = mem_q[rd_ptr_q[ADDR_W-1:0]];
    end else begin
      rd_data = 8'h00;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
//   Self-checking bench for uart_rx_fifo. A table of per-cycle vectors covers
//   single-byte latency, empty reads and long rx_done pulses. Hand-written
//   sequences cover fill/overflow, push-while-full-with-pop, pointer wrap while
//   streaming, and reset in the middle of operation.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rd_ready;
  logic       ovf_clr;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic [4:0] count;
  logic       full;
  logic       almost_full;
  logic       overflow;

  int n_pass  = 0;
  int n_total = 0;

  uart_rx_fifo #(.DEPTH(16), .ADDR_W(4), .AFULL(12)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .rd_ready    (rd_ready),
    .ovf_clr     (ovf_clr),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .count       (count),
    .full        (full),
    .almost_full (almost_full),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rx_done;
    logic [7:0] rx_data;
    logic       rd_ready;
    logic       ovf_clr;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [4:0] exp_count;
    logic       exp_full;
    logic       exp_afull;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    tick();
  endtask

  task automatic pop_byte(input string name, input logic [7:0] exp);
    chk(name, {31'd0, rd_valid}, 32'd1);
    chk(name, {24'd0, rd_data}, {24'd0, exp});
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] q [$];
    int         sent;
    int         got;
    int         cyc;

    reset    = 1'b0;
    rx_data  = 8'h00;
    rx_done  = 1'b0;
    rd_ready = 1'b0;
    ovf_clr  = 1'b0;
    #23;
    chk("reset_valid", {31'd0, rd_valid}, 32'd0);
    chk("reset_data", {24'd0, rd_data}, 32'h00);
    chk("reset_count", {27'd0, count}, 32'd0);
    chk("reset_full", {31'd0, full}, 32'd0);
    chk("reset_afull", {31'd0, almost_full}, 32'd0);
    chk("reset_ovf", {31'd0, overflow}, 32'd0);
    reset = 1'b1;
    tick();

    // Table: single-byte latency and pop, ignored empty read, and 10-clock rx_done holding 3C
    vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b0};
    for (int i = 3; i < 13; i++) begin
      vecs[i] = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 5'd1, 1'b0, 1'b0, 1'b0};
    end
    vecs[13] = '{1'b0, 8'h3C, 1'b0, 1'b1, 1'b1, 8'h3C, 5'd1, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 14; i++) begin
      rx_done  = vecs[i].rx_done;
      rx_data  = vecs[i].rx_data;
      rd_ready = vecs[i].rd_ready;
      ovf_clr  = vecs[i].ovf_clr;
      tick();
      chk($sformatf("vec%0d_valid", i), {31'd0, rd_valid}, {31'd0, vecs[i].exp_valid});
      chk($sformatf("vec%0d_data", i), {24'd0, rd_data}, {24'd0, vecs[i].exp_data});
      chk($sformatf("vec%0d_count", i), {27'd0, count}, {27'd0, vecs[i].exp_count});
      chk($sformatf("vec%0d_full", i), {31'd0, full}, {31'd0, vecs[i].exp_full});
      chk($sformatf("vec%0d_afull", i), {31'd0, almost_full}, {31'd0, vecs[i].exp_afull});
      chk($sformatf("vec%0d_ovf", i), {31'd0, overflow}, {31'd0, vecs[i].exp_ovf});
    end
    rx_done  = 1'b0;
    rd_ready = 1'b0;
    ovf_clr  = 1'b0;
    pop_byte("drain_3c", 8'h3C);
    chk("empty_after_3c", {27'd0, count}, 32'd0);

    // Fill to full, check the almost_full threshold, overflow on a drop, and drain order
    for (int i = 0; i < 16; i++) begin
      push_byte(i[7:0]);
      chk($sformatf("fill_count%0d", i), {27'd0, count}, i + 1);
      chk($sformatf("fill_afull%0d", i), {31'd0, almost_full}, (i + 1 >= 12) ? 32'd1 : 32'd0);
      chk($sformatf("fill_full%0d", i), {31'd0, full}, (i == 15) ? 32'd1 : 32'd0);
    end
    push_byte(8'hFF);
    chk("drop_ovf", {31'd0, overflow}, 32'd1);
    chk("drop_count", {27'd0, count}, 32'd16);
    for (int i = 0; i < 16; i++) begin
      pop_byte($sformatf("drain%0d", i), i[7:0]);
    end
    chk("drained_valid", {31'd0, rd_valid}, 32'd0);
    chk("drained_data", {24'd0, rd_data}, 32'h00);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", {31'd0, overflow}, 32'd0);

    // Full FIFO: a push and a pop in the same cycle are both accepted
    for (int i = 0; i < 16; i++) begin
      push_byte(8'h10 + i[7:0]);
    end
    chk("full_before", {31'd0, full}, 32'd1);
    chk("full_head", {24'd0, rd_data}, 32'h10);
    rx_data  = 8'h77;
    rx_done  = 1'b1;
    rd_ready = 1'b1;
    tick();
    rx_done  = 1'b0;
    rd_ready = 1'b0;
    chk("simul_count", {27'd0, count}, 32'd16);
    chk("simul_ovf", {31'd0, overflow}, 32'd0);
    for (int i = 1; i < 16; i++) begin
      pop_byte($sformatf("simul_drain%0d", i), 8'h10 + i[7:0]);
    end
    pop_byte("simul_last77", 8'h77);
    chk("simul_empty", {27'd0, count}, 32'd0);

    // Stream 40 bytes: push on even cycles, pop on odd cycles. The pointers wrap more than once.
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < 40 && cyc < 400) begin
      rx_done  = (cyc % 2 == 0) && (sent < 40);
      rx_data  = 8'hC0 ^ sent[7:0];
      rd_ready = (cyc % 2 == 1);
      chk($sformatf("stream_valid%0d", cyc), {31'd0, rd_valid}, (q.size() != 0) ? 32'd1 : 32'd0);
      if (rd_ready && q.size() != 0) begin
        chk($sformatf("stream_data%0d", got), {24'd0, rd_data}, {24'd0, q[0]});
        void'(q.pop_front());
        got++;
      end
      if (rx_done) begin
        q.push_back(rx_data);
        sent++;
      end
      tick();
      cyc++;
    end
    rx_done  = 1'b0;
    rd_ready = 1'b0;
    chk("stream_got", got, 32'd40);
    chk("stream_count", {27'd0, count}, 32'd0);
    chk("stream_ovf", {31'd0, overflow}, 32'd0);

    // Reset mid-operation with count=5 and overflow set, then rx_done held high across reset release
    for (int i = 0; i < 16; i++) begin
      push_byte(8'h80 + i[7:0]);
    end
    push_byte(8'hEE);
    for (int i = 0; i < 11; i++) begin
      pop_byte($sformatf("pre_rst%0d", i), 8'h80 + i[7:0]);
    end
    chk("pre_rst_count", {27'd0, count}, 32'd5);
    chk("pre_rst_ovf", {31'd0, overflow}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_count", {27'd0, count}, 32'd0);
    chk("rst_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    rx_data = 8'h5A;
    rx_done = 1'b1;
    #3;
    reset = 1'b1;
    tick();
    chk("rel_count", {27'd0, count}, 32'd1);
    chk("rel_data", {24'd0, rd_data}, 32'h5A);
    tick();
    tick();
    chk("rel_hold_count", {27'd0, count}, 32'd1);
    rx_done = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
